// File: rtl/if_id_pipe_reg.sv
// -----------------------------------------------------------------------------
// if_id_pipe_reg
//
// Pipeline register between the Instruction Fetch (IF) and Instruction
// Decode (ID) stages of the in-order RISC-V core. It captures the fetched
// instruction word and its PC on each enabled clock edge. A stall holds the
// stage. A flush replaces the stage with a bubble (NOP, RESET_PC, invalid).
//
// Update priority at each rising edge of clk: reset > flush > enable > hold.
// All outputs come straight from flops, so there is no combinational path
// from any input to any output.
//
// Parameters:
//   XLEN       width of the PC and instruction datapath
//   NOP_INSTR  instruction loaded on reset/flush (addi x0,x0,0)
//   RESET_PC   d_pc value loaded on reset/flush
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   enable      in   1 = capture IF values, 0 = hold (stall)
//   flush       in   1 = replace stage contents with a bubble
//   f_valid     in   IF-stage instruction valid
//   f_instr     in   [XLEN] fetched instruction word
//   f_pc        in   [XLEN] PC of the fetched instruction
//   d_valid     out  ID-stage instruction valid
//   d_instr     out  [XLEN] registered instruction for decode
//   d_pc        out  [XLEN] registered PC for decode
//   d_pc_plus4  out  [XLEN] registered f_pc+4 (wraps modulo 2^XLEN).
//                    Present only when IF_ID_PC_PLUS4_EN is defined.
//
// Optional feature macro: IF_ID_PC_PLUS4_EN
// -----------------------------------------------------------------------------
module if_id_pipe_reg #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] NOP_INSTR = 'h0000_0013,
   parameter logic [XLEN-1:0] RESET_PC  = 'h0000_0000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic            flush,
   input  logic            f_valid,
   input  logic [XLEN-1:0] f_instr,
   input  logic [XLEN-1:0] f_pc,
   output logic            d_valid,
   output logic [XLEN-1:0] d_instr,
   output logic [XLEN-1:0] d_pc
`ifdef IF_ID_PC_PLUS4_EN
   ,
   output logic [XLEN-1:0] d_pc_plus4
`endif
);

   // Stage state
   logic            valid_reg, valid_next;
   logic [XLEN-1:0] instr_reg, instr_next;
   logic [XLEN-1:0] pc_reg,    pc_next;

`ifdef IF_ID_PC_PLUS4_EN
   // The bubble value is a constant, so the adder is needed only on the
   // capture path.
   localparam logic [XLEN-1:0] RESET_PC_PLUS4 = RESET_PC + XLEN'(4);

   logic [XLEN-1:0] pc_plus4_reg, pc_plus4_next;
`endif

   // Next-state selection. Reset and flush both load the same bubble. Reset
   // is still ranked first so that the whole priority order is explicit.
   always_comb begin
      valid_next = valid_reg;
      instr_next = instr_reg;
      pc_next    = pc_reg;
      if (reset || flush) begin
         valid_next = 1'b0;
         instr_next = NOP_INSTR;
         pc_next    = RESET_PC;
      end else if (enable) begin
         // An invalid fetch still loads its instruction and PC. Only the
         // valid bit marks the entry as a bubble.
         valid_next = f_valid;
         instr_next = f_instr;
         pc_next    = f_pc;
      end
   end

`ifdef IF_ID_PC_PLUS4_EN
   always_comb begin
      pc_plus4_next = pc_plus4_reg;
      if (reset || flush) begin
         pc_plus4_next = RESET_PC_PLUS4;
      end else if (enable) begin
         // The carry out is dropped on purpose, so 0xFFFF_FFFC wraps to 0.
         pc_plus4_next = f_pc + XLEN'(4);
      end
   end
`endif

   always_ff @(posedge clk) begin
      valid_reg <= valid_next;
      instr_reg <= instr_next;
      pc_reg    <= pc_next;
`ifdef IF_ID_PC_PLUS4_EN
      pc_plus4_reg <= pc_plus4_next;
`endif
   end

   assign d_valid = valid_reg;
   assign d_instr = instr_reg;
   assign d_pc    = pc_reg;
`ifdef IF_ID_PC_PLUS4_EN
   assign d_pc_plus4 = pc_plus4_reg;
`endif

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_if_id_pipe_reg
//
// Self-checking bench for if_id_pipe_reg. It runs directed scenarios from
// the test plan, then a randomized stream. The random stream is checked
// against a transaction-level reference model that applies the
// reset > flush > enable > hold rule to the inputs present at each edge.
// -----------------------------------------------------------------------------
module tb_if_id_pipe_reg;

   localparam int          XLEN = 32;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [31:0] RPC  = 32'h0000_0000;

   logic            clk;
   logic            reset;
   logic            enable;
   logic            flush;
   logic            f_valid;
   logic [XLEN-1:0] f_instr;
   logic [XLEN-1:0] f_pc;
   logic            d_valid;
   logic [XLEN-1:0] d_instr;
   logic [XLEN-1:0] d_pc;
`ifdef IF_ID_PC_PLUS4_EN
   logic [XLEN-1:0] d_pc_plus4;
`endif

   int tests_run;
   int tests_failed;

   // Reference model state: what decode should see after the latest edge.
   logic        m_valid;
   logic [31:0] m_instr;
   logic [31:0] m_pc;
   logic [31:0] m_pc4;

   if_id_pipe_reg #(.XLEN(XLEN)) dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .flush   (flush),
      .f_valid (f_valid),
      .f_instr (f_instr),
      .f_pc    (f_pc),
      .d_valid (d_valid),
      .d_instr (d_instr),
      .d_pc    (d_pc)
`ifdef IF_ID_PC_PLUS4_EN
      ,
      .d_pc_plus4 (d_pc_plus4)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one rising edge. The model is updated from the inputs that the
   // DUT sees at this edge. Outputs are sampled 1 time unit after the edge.
   task automatic tick();
      if (reset || flush) begin
         m_valid = 1'b0;
         m_instr = NOP;
         m_pc    = RPC;
         m_pc4   = RPC + 32'd4;
      end else if (enable) begin
         m_valid = f_valid;
         m_instr = f_instr;
         m_pc    = f_pc;
         m_pc4   = 32'((64'(f_pc) + 64'd4) % 64'h1_0000_0000);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic fl, input logic v,
                        input logic [31:0] ins, input logic [31:0] pc);
      enable  = en;
      flush   = fl;
      f_valid = v;
      f_instr = ins;
      f_pc    = pc;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 32'h0000_00A1, 32'h0000_0049);
      for (int i = 0; i < 10; i++) begin
         tick();
         tests_run++;
         if (d_instr !== 32'h13 || d_pc !== 32'h0 || d_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_hold cyc=%0d got instr=%h pc=%h v=%b want instr=00000013 pc=00000000 v=0",
                     i, d_instr, d_pc, d_valid);
         end
      end
`ifdef IF_ID_PC_PLUS4_EN
      tests_run++;
      if (d_pc_plus4 !== 32'h4) begin
         tests_failed++;
         $display("FAIL reset_pc_plus4 got %h want 00000004", d_pc_plus4);
      end
`endif
      reset = 1'b0;
      tick();
      tests_run++;
      if (d_instr !== 32'hA1 || d_pc !== 32'h49 || d_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release got instr=%h pc=%h v=%b want instr=000000a1 pc=00000049 v=1",
                  d_instr, d_pc, d_valid);
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_back_to_back();
      logic [31:0] pcs [3];
      logic [31:0] ins [3];
      pcs = '{32'h100, 32'h104, 32'h108};
      ins = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b1, ins[i], pcs[i]);
         tick();
         tests_run++;
         if (d_instr !== ins[i] || d_pc !== pcs[i] || d_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL back_to_back i=%0d got instr=%h pc=%h v=%b want instr=%h pc=%h v=1",
                     i, d_instr, d_pc, d_valid, ins[i], pcs[i]);
         end
      end
      $display("[TB] test_back_to_back done");
   endtask

   task automatic test_stall();
      drive(1'b1, 1'b0, 1'b1, 32'h00A0_0113, 32'h104);
      tick();
      drive(1'b0, 1'b0, 1'b1, 32'h0020_81B3, 32'h108);
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if (d_pc !== 32'h104 || d_instr !== 32'h00A0_0113 || d_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_hold cyc=%0d got instr=%h pc=%h v=%b want instr=00a00113 pc=00000104 v=1",
                     i, d_instr, d_pc, d_valid);
         end
      end
      enable = 1'b1;
      tick();
      tests_run++;
      if (d_pc !== 32'h108 || d_instr !== 32'h0020_81B3) begin
         tests_failed++;
         $display("FAIL stall_release got instr=%h pc=%h want instr=002081b3 pc=00000108",
                  d_instr, d_pc);
      end
      $display("[TB] test_stall done");
   endtask

   task automatic test_flush();
      drive(1'b1, 1'b0, 1'b1, 32'h00A0_0113, 32'h104);
      tick();
      drive(1'b0, 1'b1, 1'b1, 32'h0020_81B3, 32'h108);
      tick();
      tests_run++;
      if (d_instr !== 32'h13 || d_pc !== 32'h0 || d_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_stall got instr=%h pc=%h v=%b want instr=00000013 pc=00000000 v=0",
                  d_instr, d_pc, d_valid);
      end
      drive(1'b1, 1'b0, 1'b1, 32'h1234_5678, 32'h300);
      tick();
      drive(1'b1, 1'b1, 1'b1, 32'h8765_4321, 32'h304);
      tick();
      tests_run++;
      if (d_instr !== 32'h13 || d_pc !== 32'h0 || d_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_enable got instr=%h pc=%h v=%b want instr=00000013 pc=00000000 v=0",
                  d_instr, d_pc, d_valid);
      end
      $display("[TB] test_flush done");
   endtask

   task automatic test_invalid_capture();
      drive(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h200);
      tick();
      tests_run++;
      if (d_instr !== 32'hDEAD_BEEF || d_pc !== 32'h200 || d_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL invalid_capture got instr=%h pc=%h v=%b want instr=deadbeef pc=00000200 v=0",
                  d_instr, d_pc, d_valid);
      end
      $display("[TB] test_invalid_capture done");
   endtask

`ifdef IF_ID_PC_PLUS4_EN
   task automatic test_pc_plus4();
      drive(1'b1, 1'b0, 1'b1, 32'h0000_0013, 32'hFFFF_FFFC);
      tick();
      tests_run++;
      if (d_pc_plus4 !== 32'h0 || d_pc !== 32'hFFFF_FFFC) begin
         tests_failed++;
         $display("FAIL pc_plus4_wrap got pc=%h pc4=%h want pc=fffffffc pc4=00000000",
                  d_pc, d_pc_plus4);
      end
      drive(1'b0, 1'b0, 1'b1, 32'h0000_0013, 32'h500);
      tick();
      tests_run++;
      if (d_pc_plus4 !== 32'h0) begin
         tests_failed++;
         $display("FAIL pc_plus4_hold got %h want 00000000", d_pc_plus4);
      end
      drive(1'b1, 1'b0, 1'b1, 32'h0000_0013, 32'h500);
      tick();
      tests_run++;
      if (d_pc_plus4 !== 32'h504) begin
         tests_failed++;
         $display("FAIL pc_plus4_capture got %h want 00000504", d_pc_plus4);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tests_run++;
      if (d_pc_plus4 !== 32'h4) begin
         tests_failed++;
         $display("FAIL pc_plus4_flush got %h want 00000004", d_pc_plus4);
      end
      $display("[TB] test_pc_plus4 done");
   endtask
`endif

   task automatic test_random();
      int errs;
      errs = 0;
      for (int i = 0; i < 300; i++) begin
         reset   = ($urandom_range(0, 19) == 0);
         flush   = ($urandom_range(0, 9) == 0);
         enable  = ($urandom_range(0, 9) < 7);
         f_valid = 1'($urandom_range(0, 1));
         f_instr = $urandom;
         // Bias some PCs toward the top of the address space to hit the wrap.
         f_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         tick();
         tests_run++;
         if (d_valid !== m_valid || d_instr !== m_instr || d_pc !== m_pc) begin
            tests_failed++;
            errs++;
            $display("FAIL random cyc=%0d got v=%b instr=%h pc=%h want v=%b instr=%h pc=%h",
                     i, d_valid, d_instr, d_pc, m_valid, m_instr, m_pc);
         end
`ifdef IF_ID_PC_PLUS4_EN
         tests_run++;
         if (d_pc_plus4 !== m_pc4) begin
            tests_failed++;
            errs++;
            $display("FAIL random_pc4 cyc=%0d got %h want %h", i, d_pc_plus4, m_pc4);
         end
`endif
      end
      reset = 1'b0;
      flush = 1'b0;
      $display("[TB] test_random done, %0d errors", errs);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset   = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      m_valid = 1'b0;
      m_instr = NOP;
      m_pc    = RPC;
      m_pc4   = RPC + 32'd4;
      #2;
      test_reset();
      test_back_to_back();
      test_stall();
      test_flush();
      test_invalid_capture();
`ifdef IF_ID_PC_PLUS4_EN
      test_pc_plus4();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
